sersub4: RTL and testbench
==========================

Name: sersub4

Overview:
- Bit-serial subtractor: computes D = A − B − BIN over WIDTH clock cycles using one full-subtractor cell and a borrow flop.
- Companion to the team's combinational 4-bit adder: the inverse operation, in sequential, area-lean form.
- Sits behind the tt_um top-level pin mapping; operands come from ui_in, results go to uo_out.
- Simple start/busy/done handshake.

Parameters:
- WIDTH, 4, operand and result width in bits (legal values 2..8).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk edge while idle
- a  input  WIDTH  minuend; captured when start is accepted
- b  input  WIDTH  subtrahend; captured when start is accepted
- bin  input  1  borrow-in; captured when start is accepted
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse: result valid
- diff  output  WIDTH  result; held until the next completion
- bout  output  1  borrow-out of the MSB; held with diff

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - Reset values: busy=0, done=0, diff=0, bout=0, state=IDLE, bit counter=0, borrow flop=0, operand shift registers=0.
- State machine, IDLE:
  - start=1 at edge k: capture a, b, bin into shift registers and borrow flop; counter=0; go to SHIFT.
  - busy=1 after edge k.
- State machine, SHIFT, edges k+1 .. k+WIDTH:
  - Take LSB of A-reg and B-reg with borrow flop br.
  - d_i = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - Shift d_i into result shift register MSB-first-in (LSB ends at bit 0 after WIDTH shifts). Shift A-reg and B-reg right. Counter++.
- Completion, edge k+WIDTH:
  - diff ← result register; bout ← final br.
  - done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: done and valid diff appear WIDTH cycles after the start edge. Throughput is one operation per WIDTH cycles.
- diff and bout change only at completion. They keep the previous result while busy.
- Arithmetic: diff = (a − b − bin) mod 2^WIDTH. bout=1 iff a < b + bin (unsigned).
- Boundary conditions:
  - start while busy: ignored; operands are not re-captured.
  - start in the done cycle: state is IDLE, so it is accepted; back-to-back operation with no gap is legal.
  - a, b, bin changing while busy: no effect.
  - Reset asserted mid-operation: abort immediately to reset values; no done pulse.
  - Counter is sized ceil(log2(WIDTH+1)) and never wraps past WIDTH.

Optional Feature:
- Macro: SERSUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), a two's-complement overflow flag.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), evaluated on captured operands. The bin borrow is folded into diff, so the diff MSB accounts for it.
  - Updated with diff at completion, held otherwise, reset to 0.
- Not defined: no ovf port and no overflow logic; behaviour otherwise identical.

Test Plan:
- a=9, b=3, bin=0, start pulse -> after 4 cycles done=1 for one cycle, diff=6, bout=0, busy low.
- a=3, b=9, bin=0 -> diff=0xA, bout=1.
- a=0, b=0, bin=1 -> diff=0xF, bout=1. Then a=5, b=5, bin=0 started in the done cycle -> accepted, done 4 cycles later, diff=0, bout=0.
- Start a=9, b=3; pulse start with a=1, b=1 two cycles later -> ignored; result diff=6 at the original cycle, only one done pulse.
- Start a=9, b=3; assert rst_n=0 at cycle 2 -> busy, done, diff, bout immediately 0; no done after release; next start operates normally.
- With SERSUB_OVF_EN: a=7, b=8 -> diff=0xF, bout=1, ovf=1. Then a=7, b=1 -> diff=6, ovf=0.

Source files
------------

// File: rtl/sersub4.sv
// sersub4: bit-serial subtractor, D = A - B - BIN over WIDTH clocks.
// One full-subtractor cell plus a borrow flop, with a start/busy/done handshake.
// Optional build macro SERSUB_OVF_EN adds a two's-complement overflow output (ovf).
module sersub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  // Full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fsub(input logic ai, input logic bi, input logic br);
    fsub = {(~ai & bi) | (~(ai ^ bi) & br), ai ^ bi ^ br};
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  // Holds the WIDTH-1 difference bits produced before the final shift;
  // the last bit is merged straight into diff at completion.
  logic [WIDTH-2:0] res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERSUB_OVF_EN
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             ovf_q, ovf_d;
`endif

  logic [1:0]       cell_s;
  logic [WIDTH-1:0] res_shift_s;

  // Next-state logic: capture on accepted start, one cell evaluation per SHIFT cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    br_d        = br_q;
    areg_d      = areg_q;
    breg_d      = breg_q;
    res_d       = res_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    diff_d      = diff_q;
    bout_d      = bout_q;
`ifdef SERSUB_OVF_EN
    amsb_d      = amsb_q;
    bmsb_d      = bmsb_q;
    ovf_d       = ovf_q;
`endif
    cell_s      = fsub(areg_q[0], breg_q[0], br_q);
    res_shift_s = {cell_s[0], res_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          areg_d  = a;
          breg_d  = b;
          br_d    = bin;
          cnt_d   = {CW{1'b0}};
          res_d   = {(WIDTH-1){1'b0}};
          busy_d  = 1'b1;
          state_d = S_SHIFT;
`ifdef SERSUB_OVF_EN
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        areg_d = {1'b0, areg_q[WIDTH-1:1]};
        breg_d = {1'b0, breg_q[WIDTH-1:1]};
        br_d   = cell_s[1];
        res_d  = res_shift_s[WIDTH-1:1];
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = res_shift_s;
          bout_d  = cell_s[1];
`ifdef SERSUB_OVF_EN
          ovf_d   = (amsb_q != bmsb_q) && (res_shift_s[WIDTH-1] != amsb_q);
`endif
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      br_q    <= 1'b0;
      areg_q  <= {WIDTH{1'b0}};
      breg_q  <= {WIDTH{1'b0}};
      res_q   <= {(WIDTH-1){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= {WIDTH{1'b0}};
      bout_q  <= 1'b0;
`ifdef SERSUB_OVF_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERSUB_OVF_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERSUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sersub4.sv
// Self-checking bench for sersub4: arithmetic reference model compared every
// cycle, plus directed operations with hand-computed expected results.
module tb_sersub4;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERSUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  sersub4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERSUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: an operation accepted at an edge finishes W edges later.
  bit m_busy = 1'b0, m_done = 1'b0, m_bout = 1'b0, m_ovf = 1'b0;
  int m_diff = 0, m_left = 0;
  int p_diff = 0;
  bit p_bout = 1'b0, p_ovf = 1'b0;

  always @(posedge clk) begin
    if (rst_n) begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_diff = p_diff;
          m_bout = p_bout;
          m_ovf  = p_ovf;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_left = W;
        p_diff = (int'(a) + MOD - int'(b) - int'(bin)) % MOD;
        p_bout = int'(a) < int'(b) + int'(bin);
        p_ovf  = (a[W-1] != b[W-1]) && (((p_diff >> (W-1)) & 1) != int'(a[W-1]));
      end
    end
  end

  always @(negedge rst_n) begin
    m_busy = 1'b0; m_done = 1'b0; m_diff = 0; m_bout = 1'b0; m_ovf = 1'b0; m_left = 0;
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("model_busy", int'(busy), int'(m_busy));
      chk("model_done", int'(done), int'(m_done));
      chk("model_diff", int'(diff), m_diff);
      chk("model_bout", int'(bout), int'(m_bout));
`ifdef SERSUB_OVF_EN
      chk("model_ovf", int'(ovf), int'(m_ovf));
`endif
    end
  end

  // Pulse start for one cycle from a falling edge; scramble inputs afterwards.
  task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  // Wait (bounded) for done; cyc counts falling edges after the start edge.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3 * W) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bi, input int ed, input int eb);
    int cyc;
    drive_start(av, bv, bi);
    wait_done(cyc);
    chk({name, "_latency"}, cyc, W);
    chk({name, "_diff"}, int'(diff), ed);
    chk({name, "_bout"}, int'(bout), eb);
  endtask

  initial begin
    int cyc;
    int npulse;
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_diff", int'(diff), 0);
    chk("reset_bout", int'(bout), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    run_op("op_9_3", 4'd9, 4'd3, 1'b0, 6, 0);
    @(negedge clk);
    chk("op_9_3_done_pulse", int'(done), 0);
    chk("op_9_3_idle", int'(busy), 0);

    run_op("op_3_9", 4'd3, 4'd9, 1'b0, 10, 1);
    @(negedge clk);

    run_op("op_0_0_1", 4'd0, 4'd0, 1'b1, 15, 1);
    // Start issued inside the done cycle: back-to-back acceptance.
    run_op("b2b_5_5", 4'd5, 4'd5, 1'b0, 0, 0);

    // Start while busy must be ignored.
    @(negedge clk);
    drive_start(4'd9, 4'd3, 1'b0);
    @(negedge clk);
    a = 4'd1; b = 4'd1; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 2;
    while (done !== 1'b1 && cyc < 3 * W) begin
      @(negedge clk);
      cyc++;
    end
    chk("ignore_latency", cyc, W);
    chk("ignore_diff", int'(diff), 6);
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) npulse++;
    end
    chk("ignore_single_done", npulse, 0);

    // Reset mid-operation aborts at once.
    drive_start(4'd9, 4'd3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_diff", int'(diff), 0);
    chk("abort_bout", int'(bout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) npulse++;
    end
    chk("abort_no_done", npulse, 0);
    run_op("after_abort_7_2", 4'd7, 4'd2, 1'b0, 5, 0);
    @(negedge clk);

`ifdef SERSUB_OVF_EN
    run_op("ovf_7_8", 4'd7, 4'd8, 1'b0, 15, 1);
    chk("ovf_7_8_flag", int'(ovf), 1);
    @(negedge clk);
    run_op("ovf_7_1", 4'd7, 4'd1, 1'b0, 6, 0);
    chk("ovf_7_1_flag", int'(ovf), 0);
    @(negedge clk);
`endif

    // Randomized traffic, including starts while busy and one reset pulse.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 2) == 0);
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      rst_n = (i != 700);
      @(negedge clk);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2 * W) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
